// File: rtl/apb_spi_master_gen.sv
// APB-slave SPI master with programmable word length, CPOL/CPHA, bit order and SCK divider.
// Includes TX/RX FIFOs and active-low slave selects.

module apb_spi_master_gen_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module apb_spi_master_gen #(
    parameter int FIFO_DEPTH = 4,
    parameter int NSS        = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              apbi_psel,
    input  logic              apbi_penable,
    input  logic [ADDR_W-1:0] apbi_paddr,
    input  logic              apbi_pwrite,
    input  logic [31:0]       apbi_pwdata,
    output logic [31:0]       apbo_prdata,
    output logic              apbo_pready,
    output logic              apbo_pslverr,
    output logic              apbo_pirq,
    input  logic              spii_miso,
    output logic              spio_mosi,
    output logic              spio_sck,
    output logic [NSS-1:0]    slvsel
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(8'h0C);

    state_t         state, next_state;
    logic           en, cpol, cpha, lsbf, ie;
    logic [4:0]     len_m1;
    logic [NSS-1:0] ssmask;
    logic [7:0]     clkdiv;
    logic           rxovf, txovf;

    logic           cpha_l, lsbf_l;
    logic [4:0]     len_l;
    logic [7:0]     div_l;
    logic [31:0]    tx_sr, rx_sr;
    logic [7:0]     hp_cnt;
    logic [6:0]     edge_cnt;
    logic           tx_pending;

    logic access, wr, rd, sel_ctrl, sel_stat, sel_tx, sel_rx, hit;
    logic tx_push, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
    logic [31:0] tx_rdata, rx_rdata, tx_wdata, rx_word, load_sr, ctrl_rd;
    logic load, tick, do_edge, sample, drive, rx_push, go_idle, busy, first_bit, cur_bit;
    logic [6:0] last_edge;

    function automatic logic [31:0] shift_word(input logic [31:0] w, input logic lsb_first);
        return lsb_first ? (w >> 1) : (w << 1);
    endfunction

    assign access       = apbi_psel & apbi_penable;
    assign wr           = access & apbi_pwrite;
    assign rd           = access & ~apbi_pwrite;
    assign sel_ctrl     = (apbi_paddr == A_CTRL);
    assign sel_stat     = (apbi_paddr == A_STAT);
    assign sel_tx       = (apbi_paddr == A_TX);
    assign sel_rx       = (apbi_paddr == A_RX);
    assign hit          = sel_ctrl | sel_stat | sel_tx | sel_rx;
    assign apbo_pready  = 1'b1;
    assign apbo_pslverr = access & ~hit;

    assign busy      = (state != IDLE);
    assign apbo_pirq = ie & tx_empty & ~busy & en;

    assign tx_push  = wr & sel_tx;
    assign tx_wdata = apbi_pwdata & (32'hFFFF_FFFF >> (5'd31 - len_m1));
    assign rx_pop   = rd & sel_rx;

    apb_spi_master_gen_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push), .pop(load), .wdata(tx_wdata),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    apb_spi_master_gen_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push), .pop(rx_pop), .wdata(rx_word),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    // MSB-first words are pre-aligned so the outgoing bit is always tx_sr[31].
    assign load_sr   = lsbf ? tx_rdata : (tx_rdata << (5'd31 - len_m1));
    assign first_bit = lsbf ? load_sr[0] : load_sr[31];
    assign cur_bit   = lsbf_l ? tx_sr[0] : tx_sr[31];
    assign rx_word   = lsbf_l ? (rx_sr >> (5'd31 - len_l))
                              : (rx_sr & (32'hFFFF_FFFF >> (5'd31 - len_l)));
    assign last_edge = {1'b0, len_l, 1'b1};
    assign tick      = (hp_cnt == div_l);
    assign sample    = do_edge & (edge_cnt[0] == cpha_l);
    assign drive     = do_edge & (edge_cnt[0] != cpha_l) & (edge_cnt != last_edge);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en <= 1'b0; cpol <= 1'b0; cpha <= 1'b0; lsbf <= 1'b0; ie <= 1'b0;
            len_m1 <= '0; ssmask <= '0; clkdiv <= '0;
            rxovf <= 1'b0; txovf <= 1'b0; tx_pending <= 1'b0;
        end else begin
            if (wr && sel_ctrl) begin
                en     <= apbi_pwdata[0];
                cpol   <= apbi_pwdata[1];
                cpha   <= apbi_pwdata[2];
                lsbf   <= apbi_pwdata[3];
                len_m1 <= apbi_pwdata[8:4];
                ie     <= apbi_pwdata[9];
                ssmask <= apbi_pwdata[16 +: NSS];
                clkdiv <= apbi_pwdata[31:24];
            end
            if (rx_push && rx_full && !rx_pop)  rxovf <= 1'b1;
            else if (wr && sel_stat && apbi_pwdata[5]) rxovf <= 1'b0;
            if (tx_push && tx_full && !load)    txovf <= 1'b1;
            else if (wr && sel_stat && apbi_pwdata[6]) txovf <= 1'b0;
            // Registered launch qualifier: a word written at edge T starts at T+2.
            tx_pending <= ~tx_empty;
        end
    end

    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[0]         = en;
        ctrl_rd[1]         = cpol;
        ctrl_rd[2]         = cpha;
        ctrl_rd[3]         = lsbf;
        ctrl_rd[8:4]       = len_m1;
        ctrl_rd[9]         = ie;
        ctrl_rd[16 +: NSS] = ssmask;
        ctrl_rd[31:24]     = clkdiv;
        apbo_prdata        = '0;
        if (apbi_psel) begin
            if (sel_ctrl)                apbo_prdata = ctrl_rd;
            else if (sel_stat)           apbo_prdata = {25'b0, txovf, rxovf, rx_empty, rx_full,
                                                        tx_empty, tx_full, busy};
            else if (sel_rx && !rx_empty) apbo_prdata = rx_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        do_edge    = 1'b0;
        rx_push    = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: begin
                if (en && tx_pending && !tx_empty) begin
                    load       = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP, SHIFT: begin
                if (!en) begin
                    go_idle    = 1'b1;
                    next_state = IDLE;
                end else if (tick) begin
                    if (edge_cnt <= last_edge) begin
                        do_edge    = 1'b1;
                        next_state = SHIFT;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                rx_push = 1'b1;
                if (en && tx_pending && !tx_empty) begin
                    load       = 1'b1;
                    next_state = SETUP;
                end else begin
                    go_idle    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spio_sck  <= 1'b0;
            spio_mosi <= 1'b0;
            slvsel    <= '1;
            tx_sr     <= '0;
            rx_sr     <= '0;
            hp_cnt    <= '0;
            edge_cnt  <= '0;
            cpha_l    <= 1'b0;
            lsbf_l    <= 1'b0;
            len_l     <= '0;
            div_l     <= '0;
        end else if (load) begin
            cpha_l    <= cpha;
            lsbf_l    <= lsbf;
            len_l     <= len_m1;
            div_l     <= clkdiv;
            spio_sck  <= cpol;
            slvsel    <= ~ssmask;
            spio_mosi <= first_bit;
            // With CPHA=0 the first bit is already on the line, so the register moves past it.
            tx_sr     <= cpha ? load_sr : shift_word(load_sr, lsbf);
            rx_sr     <= '0;
            hp_cnt    <= '0;
            edge_cnt  <= '0;
        end else if (go_idle || state == IDLE) begin
            spio_sck  <= cpol;
            spio_mosi <= 1'b0;
            slvsel    <= '1;
        end else if (state == SETUP || state == SHIFT) begin
            hp_cnt <= tick ? '0 : hp_cnt + 1'b1;
            if (do_edge) begin
                spio_sck <= ~spio_sck;
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (drive) begin
                spio_mosi <= cur_bit;
                tx_sr     <= shift_word(tx_sr, lsbf_l);
            end
            if (sample) rx_sr <= lsbf_l ? {spii_miso, rx_sr[31:1]} : {rx_sr[30:0], spii_miso};
        end
    end
endmodule

// File: tb/tb_apb_spi_master_gen.sv
// Directed self-checking bench for apb_spi_master_gen: modes, bit order, back-to-back,
// FIFO overflow, abort, unmapped access and asynchronous reset.

module tb_apb_spi_master_gen;
    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_STAT = 8'h04;
    localparam logic [7:0] A_TX   = 8'h08;
    localparam logic [7:0] A_RX   = 8'h0C;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, pirq;
    logic        miso, mosi, sck;
    logic [3:0]  slvsel;
    logic        loop_en = 1'b1;
    logic        miso_val = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    assign miso = loop_en ? mosi : miso_val;

    always #5 clk = ~clk;

    apb_spi_master_gen #(.FIFO_DEPTH(4), .NSS(4), .ADDR_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .apbi_psel(psel), .apbi_penable(penable), .apbi_paddr(paddr),
        .apbi_pwrite(pwrite), .apbi_pwdata(pwdata),
        .apbo_prdata(prdata), .apbo_pready(pready), .apbo_pslverr(pslverr), .apbo_pirq(pirq),
        .spii_miso(miso), .spio_mosi(mosi), .spio_sck(sck), .slvsel(slvsel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Follows one slvsel[0] low window: launch latency, low length, sck edges, captured mosi bits.
    task automatic watch(input logic cpha, output int lat, output int low_cyc,
                         output int edges, output logic [31:0] bits);
        int   k;
        logic prev;
        lat = -1; low_cyc = 0; edges = 0; bits = '0; k = 0;
        while (slvsel[0] && k < 100) begin
            @(negedge clk);
            if (!slvsel[0]) lat = k;
            else k++;
        end
        prev = sck;
        while (!slvsel[0] && low_cyc < 2000) begin
            low_cyc++;
            @(negedge clk);
            if (sck !== prev) begin
                edges++;
                if ((edges % 2 == 1) != cpha) bits = {bits[30:0], mosi};
                prev = sck;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdv, bits;
        logic        err;
        int          lat, low, edges, k;
        logic        prev;

        // Power-on reset state
        repeat (3) @(negedge clk);
        check("rst_slvsel", {28'b0, slvsel}, 32'hF);
        check("rst_sck", {31'b0, sck}, 0);
        check("rst_mosi", {31'b0, mosi}, 0);
        check("rst_pirq", {31'b0, pirq}, 0);
        check("rst_prdata", prdata, 0);
        check("rst_pready", {31'b0, pready}, 1);
        rstn = 1'b1;
        apb_read(A_STAT, rdv, err);
        check("rst_status", rdv, 32'h14);
        apb_read(A_CTRL, rdv, err);
        check("rst_ctrl", rdv, 0);

        // Mode 0, MSB-first, LEN=8, CLKDIV=1, SSMASK=1, IE=1, loopback
        apb_write(A_CTRL, 32'h0101_0271);
        apb_read(A_CTRL, rdv, err);
        check("ctrl_readback", rdv, 32'h0101_0271);
        apb_write(A_TX, 32'hA5);
        check("m0_pirq_pending", {31'b0, pirq}, 0);
        watch(1'b0, lat, low, edges, bits);
        check("m0_latency", lat, 2);
        check("m0_low_cycles", low, 35);
        check("m0_sck_edges", edges, 16);
        check("m0_mosi_bits", bits, 32'hA5);
        check("m0_slvsel_idle", {28'b0, slvsel}, 32'hF);
        apb_read(A_RX, rdv, err);
        check("m0_rxdata", rdv, 32'hA5);
        check("m0_pirq_done", {31'b0, pirq}, 1);

        // Mode 3, LSB-first, LEN=16, miso tied high
        loop_en = 1'b0; miso_val = 1'b1;
        apb_write(A_CTRL, 32'h0101_00FF);
        repeat (2) @(negedge clk);
        check("m3_sck_idle_high", {31'b0, sck}, 1);
        apb_write(A_TX, 32'h1234);
        watch(1'b1, lat, low, edges, bits);
        check("m3_latency", lat, 2);
        check("m3_low_cycles", low, 67);
        check("m3_sck_edges", edges, 32);
        check("m3_mosi_bits", bits, 32'h2C48);
        check("m3_first_mosi", {31'b0, bits[15]}, 0);
        check("m3_sck_after", {31'b0, sck}, 1);
        apb_read(A_RX, rdv, err);
        check("m3_rxdata", rdv, 32'hFFFF);
        loop_en = 1'b1;

        // Back-to-back: three words at CLKDIV=0
        apb_write(A_CTRL, 32'h0001_0071);
        apb_write(A_TX, 32'h11);
        fork
            watch(1'b0, lat, low, edges, bits);
            begin
                apb_write(A_TX, 32'h22);
                apb_write(A_TX, 32'h33);
            end
        join
        check("b2b_latency", lat, 2);
        check("b2b_low_cycles", low, 54);
        check("b2b_sck_edges", edges, 48);
        check("b2b_mosi_bits", bits, 32'h112233);
        apb_read(A_RX, rdv, err);
        check("b2b_rx0", rdv, 32'h11);
        apb_read(A_RX, rdv, err);
        check("b2b_rx1", rdv, 32'h22);
        apb_read(A_RX, rdv, err);
        check("b2b_rx2", rdv, 32'h33);
        apb_read(A_RX, rdv, err);
        check("b2b_rx_empty", rdv, 0);

        // Overflow: fill TX with EN=0, then run five transfers with no RX reads
        apb_write(A_CTRL, 32'h0001_0070);
        for (int i = 1; i <= 5; i++) apb_write(A_TX, 32'(i));
        apb_read(A_STAT, rdv, err);
        check("ovf_tx_status", rdv, 32'h52);
        apb_write(A_CTRL, 32'h0001_0071);
        apb_write(A_TX, 32'h06);
        k = 0;
        rdv = 32'h1;
        while (((rdv & 32'h5) != 32'h4) && k < 200) begin
            apb_read(A_STAT, rdv, err);
            k++;
        end
        check("ovf_drain_in_time", {31'b0, (k < 200)}, 1);
        check("ovf_status", rdv, 32'h6C);
        apb_write(A_STAT, 32'h60);
        apb_read(A_STAT, rdv, err);
        check("ovf_w1c_status", rdv, 32'h0C);
        for (int i = 1; i <= 4; i++) begin
            apb_read(A_RX, rdv, err);
            check($sformatf("ovf_rx%0d", i), rdv, 32'(i));
        end
        apb_read(A_STAT, rdv, err);
        check("ovf_final_status", rdv, 32'h14);

        // Abort after three sck edges, then error and empty reads
        apb_write(A_CTRL, 32'h0301_0071);
        apb_write(A_TX, 32'h5A);
        edges = 0; k = 0; prev = sck;
        while (edges < 3 && k < 200) begin
            @(negedge clk);
            if (sck !== prev) begin edges++; prev = sck; end
            k++;
        end
        check("abort_edges_seen", {31'b0, (edges >= 3)}, 1);
        apb_write(A_CTRL, 32'h0301_0070);
        @(negedge clk);
        check("abort_slvsel_same_clk", {28'b0, slvsel}, 32'hE);
        @(negedge clk);
        check("abort_slvsel_next_clk", {28'b0, slvsel}, 32'hF);
        check("abort_sck", {31'b0, sck}, 0);
        check("abort_mosi", {31'b0, mosi}, 0);
        apb_read(A_STAT, rdv, err);
        check("abort_status", rdv, 32'h14);
        apb_read(8'h10, rdv, err);
        check("unmapped_pslverr", {31'b0, err}, 1);
        check("unmapped_prdata", rdv, 0);
        apb_read(A_RX, rdv, err);
        check("rx_empty_read", rdv, 0);
        check("rx_empty_pslverr", {31'b0, err}, 0);
        apb_read(A_TX, rdv, err);
        check("txdata_read_zero", rdv, 0);

        // Asynchronous reset in the middle of a CPOL=1 transfer
        apb_write(A_CTRL, 32'h0101_0073);
        apb_write(A_TX, 32'h3C);
        repeat (10) @(negedge clk);
        check("midrun_active", {28'b0, slvsel}, 32'hE);
        #2;
        rstn = 1'b0;
        #1;
        check("midrun_rst_slvsel", {28'b0, slvsel}, 32'hF);
        check("midrun_rst_sck", {31'b0, sck}, 0);
        check("midrun_rst_pirq", {31'b0, pirq}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        apb_read(A_STAT, rdv, err);
        check("midrun_rst_status", rdv, 32'h14);
        apb_read(A_CTRL, rdv, err);
        check("midrun_rst_ctrl", rdv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_spi_master_gen.md
Name: apb_spi_master_gen

Overview:
Parametrised APB-slave SPI master, successor to the fixed-configuration spi_wrap/spictrl integration.
- Programmable word length (1..32 bits), all four CPOL/CPHA modes, MSB/LSB first, and a programmable SCK divider.
- TX and RX FIFOs of parametrised depth, plus NSS active-low slave selects.
- Sits on the peripheral APB bus next to spi_wrap and drives off-chip SPI devices.

Parameters:
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, >=2)
NSS, 4, number of slave-select outputs (1..8)
ADDR_W, 8, APB address bits decoded (only paddr[ADDR_W-1:0] is used)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
apbi_psel  in  1  APB select
apbi_penable  in  1  APB enable phase
apbi_paddr  in  ADDR_W  APB byte address
apbi_pwrite  in  1  APB write
apbi_pwdata  in  32  APB write data
apbo_prdata  out  32  APB read data
apbo_pready  out  1  tied 1 (zero wait states)
apbo_pslverr  out  1  error on unmapped access
apbo_pirq  out  1  level interrupt
spii_miso  in  1  serial data in
spio_mosi  out  1  serial data out
spio_sck  out  1  serial clock
slvsel  out  NSS  slave selects, active low

Behaviour:
- Reset (async, rstn=0): all registers 0, FIFOs empty, FSM in IDLE. Outputs: sck=0, mosi=0, slvsel all 1, prdata=0, pslverr=0, pirq=0.
- Access strobe: psel & penable. Writes take effect on that clk edge. prdata is combinational from the address during the access.
- pslverr=1 during an access phase to any address other than 0x00/04/08/0C; such writes are ignored and reads return 0.
- CTRL 0x00 RW:
  - [0] EN, [1] CPOL, [2] CPHA, [3] LSBF.
  - [8:4] LEN-1, giving word length 1..32.
  - [9] IE.
  - [16+NSS-1:16] SSMASK.
  - [31:24] CLKDIV: SCK half-period is CLKDIV+1 clk.
- STATUS 0x04:
  - [0] BUSY, [1] TXFULL, [2] TXEMPTY, [3] RXFULL, [4] RXEMPTY: read-only.
  - [5] RXOVF: sticky, write-1-to-clear.
  - [6] TXOVF: sticky, write-1-to-clear.
- TXDATA 0x08 (write-only; reads return 0): a write pushes pwdata[LEN-1:0]. If the TX FIFO is full, the write is dropped and TXOVF is set.
- RXDATA 0x0C (read-only): a read returns the FIFO head (zero-extended) and pops it. A read when empty returns 0 with no pop.
- pirq = IE & TXEMPTY & !BUSY & EN (level).
- FSM states IDLE, SETUP, SHIFT, DONE.
  - IDLE: if EN & !TXEMPTY: pop word into the shift register, drive first bit on mosi, assert slvsel[i]=0 for every SSMASK[i]=1, go to SETUP. BUSY=1 in every state except IDLE.
  - SETUP: hold one half-period (CLKDIV+1 clk), then go to SHIFT.
  - SHIFT: sck toggles every half-period, 2*LEN edges in total.
    - CPHA=0: sample miso on odd (leading) edges; drive the next bit on even edges, except after the last edge.
    - CPHA=1: drive a bit on odd edges; sample on even edges.
    - Bit order is MSB-first (bit LEN-1 first) unless LSBF=1.
    - After the 2*LEN-th edge, go to DONE.
  - DONE (1 clk): push the received word to the RX FIFO. If the RX FIFO is full, drop the word and set RXOVF.
    - If EN & !TXEMPTY: load the next word and go to SETUP; slvsel stays low (back-to-back).
    - Otherwise: slvsel all 1, mosi=0, go to IDLE.
- Idle SCK level follows CPOL at all times when not shifting.
- EN cleared mid-word: next clk goes to IDLE; sck=CPOL, slvsel all 1, current word discarded (no RX push). FIFO contents are kept.
- CTRL writes while BUSY: only EN and IE take effect immediately. The mode, LEN, CLKDIV and SSMASK fields used by the transfer are latched at IDLE/DONE load time.
- Simultaneous TX push and pop: the push is accepted when the FIFO is full at that edge only if a pop also occurs. The same rule applies to the RX FIFO (RX pop by APB read plus push in DONE).
- Latency:
  - The TXDATA write edge lands at cycle T; slvsel falls at T+2.
  - The first sck edge is at T+2+(CLKDIV+1).
  - slvsel rises 1+(2*LEN+1)*(CLKDIV+1) clk after falling.

Test Plan:
1. Reset: rstn low mid-run -> immediately slvsel=all 1, sck=0, STATUS reads 0x14 (TXEMPTY|RXEMPTY), pirq=0.
2. Mode 0, MSB-first, LEN=8, CLKDIV=1, SSMASK=0x1, miso looped to mosi; write TXDATA=0xA5 -> mosi bits 1,0,1,0,0,1,0,1; slvsel[0] low for 35 clk; RXDATA reads 0x000000A5; pirq=1 with IE=1.
3. Mode 3, LSBF=1, LEN=16, miso=1 constant; write 0x1234 -> sck idles high, first mosi bit 0 (bit 0), RXDATA=0x0000FFFF.
4. Back-to-back: write 3 words with LEN=8 -> slvsel stays low across all words (one DONE clk between words); RX holds 3 entries in order.
5. Overflow: FIFO_DEPTH=4 with EN=0, write 5 TX words -> TXFULL=1, TXOVF=1, 5th word lost. Enable with no RX reads over 5 total transfers -> RXOVF=1; W1C 0x60 clears both.
6. Abort and errors: clear EN after 3 sck edges -> slvsel high next clk, no RX push. Read 0x10 -> pslverr=1, prdata=0. Read empty RXDATA -> 0.
